// File: rtl/tmds_timing_pkg.sv
// Shared constants and types for the TX-side 720p TMDS timing generator.
package tmds_timing_pkg;

    // 720p60 default timing
    localparam int unsigned DEF_H_ACTIVE = 1280;
    localparam int unsigned DEF_H_FP     = 110;
    localparam int unsigned DEF_H_SYNC   = 40;
    localparam int unsigned DEF_H_BP     = 220;
    localparam int unsigned DEF_V_ACTIVE = 720;
    localparam int unsigned DEF_V_FP     = 5;
    localparam int unsigned DEF_V_SYNC   = 5;
    localparam int unsigned DEF_V_BP     = 20;

    // Derived positions for the default timing (sync first, then back porch, active, front porch)
    localparam int unsigned H_TOTAL     = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned V_TOTAL     = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int unsigned H_ACT_START = DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned H_ACT_END   = H_ACT_START + DEF_H_ACTIVE;
    localparam int unsigned V_ACT_START = DEF_V_SYNC + DEF_V_BP;
    localparam int unsigned V_ACT_END   = V_ACT_START + DEF_V_ACTIVE;
    localparam int unsigned H_HALF      = H_ACT_START + DEF_H_ACTIVE / 2;

    // Datapath widths
    localparam int unsigned CNT_W = 11;
    localparam int unsigned IDX_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/tmds_timing_cnt.sv
// Horizontal/vertical raster counter with clear and advance controls.
module tmds_timing_cnt
    import tmds_timing_pkg::*;
#(
    parameter int unsigned H_TOT = H_TOTAL,
    parameter int unsigned V_TOT = V_TOTAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             frame_end
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;

    // Next raster position: clear wins, otherwise step h and carry into v on wrap
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        h_d = h_q;
        v_d = v_q;
        if (clear) begin
            h_d = '0;
            v_d = '0;
        end else if (run) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
            end else begin
                h_d = h_q + CNT_W'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_cnt     = h_q;
    assign v_cnt     = v_q;
    assign frame_end = (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/tmds_timing_gen.sv
// TX video timing generator: syncs, data enable, FIFO pull request and FIFO-side counters.
module tmds_timing_gen
    import tmds_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        SYNC_POL = 1'b1
) (
    input  logic             tx0_pclk,
    input  logic             rstbtn_n,
    input  logic             en,
    output logic             hsync,
    output logic             vsync,
    output logic             pix_req,
    output logic             video_en,
    output logic [CNT_W-1:0] video_hcnt,
    output logic [CNT_W-1:0] video_vcnt,
    output logic [IDX_W-1:0] index,
    output logic             frame_start,
    output logic             busy
);

    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] HA_START = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] HA_END   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] HA_HALF  = CNT_W'(H_SYNC + H_BP + H_ACTIVE / 2);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] VA_START = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] VA_END   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] h_cnt, v_cnt, h_nxt;
    logic             frame_end, running;
    logic             h_act, h_act_nxt, v_act;

    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             pix_req_q, pix_req_d, video_en_q, video_en_d;
    logic [CNT_W-1:0] video_hcnt_q, video_hcnt_d, video_vcnt_q, video_vcnt_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             frame_start_q, frame_start_d, busy_q, busy_d;

    assign running = (state_q != IDLE);

    tmds_timing_cnt #(
        .H_TOT(H_TOT),
        .V_TOT(V_TOT)
    ) u_cnt (
        .clk      (tx0_pclk),
        .rst      (rstbtn_n),
        .clear    (!running),
        .run      (running),
        .h_cnt    (h_cnt),
        .v_cnt    (v_cnt),
        .frame_end(frame_end)
    );

    // State register
    always_ff @(posedge tx0_pclk) begin
        if (rstbtn_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state: en starts/resumes the raster; dropping it only finishes the current frame
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = DRAIN;
            DRAIN:   if (en) state_d = RUN;
                     else if (frame_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign h_nxt     = h_cnt + CNT_W'(1);
    assign h_act     = (h_cnt >= HA_START) && (h_cnt < HA_END);
    assign h_act_nxt = (h_nxt >= HA_START) && (h_nxt < HA_END);
    assign v_act     = (v_cnt >= VA_START) && (v_cnt < VA_END);

    // Region decode of the current raster position into next-cycle output values
    always_comb begin
        hsync_d       = ~SYNC_POL;
        vsync_d       = ~SYNC_POL;
        pix_req_d     = 1'b0;
        video_en_d    = 1'b0;
        video_hcnt_d  = '0;
        video_vcnt_d  = '0;
        index_d       = index_q;
        frame_start_d = 1'b0;
        busy_d        = 1'b0;
        if (running) begin
            hsync_d       = (h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync_d       = (v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
            pix_req_d     = h_act_nxt && v_act;
            video_en_d    = h_act && v_act;
            video_hcnt_d  = (h_act && v_act) ? h_cnt - HA_START : '0;
            video_vcnt_d  = v_act ? v_cnt - VA_START : '0;
            frame_start_d = (h_cnt == '0) && (v_cnt == '0);
            busy_d        = 1'b1;
            // Two FIFO blocks per active line: one at line start, one at the half-line point
            if ((v_cnt == VA_START) && (h_cnt == HA_START)) begin
                index_d = '0;
            end else if (v_act && ((h_cnt == HA_START) || (h_cnt == HA_HALF))) begin
                index_d = index_q + IDX_W'(1);
            end
        end
    end

    // Output registers
    always_ff @(posedge tx0_pclk) begin
        if (rstbtn_n) begin
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            pix_req_q     <= 1'b0;
            video_en_q    <= 1'b0;
            video_hcnt_q  <= '0;
            video_vcnt_q  <= '0;
            index_q       <= '0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            pix_req_q     <= pix_req_d;
            video_en_q    <= video_en_d;
            video_hcnt_q  <= video_hcnt_d;
            video_vcnt_q  <= video_vcnt_d;
            index_q       <= index_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign pix_req     = pix_req_q;
    assign video_en    = video_en_q;
    assign video_hcnt  = video_hcnt_q;
    assign video_vcnt  = video_vcnt_q;
    assign index       = index_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_tmds_timing_gen.sv
// Bench for tmds_timing_gen using a reduced raster so whole frames fit in a short run.
// A positional (linear pixel number) reference model predicts every output each cycle.
module tb_tmds_timing_gen;

    localparam int HA = 16, HFP = 3, HS = 4, HBP = 5;
    localparam int VA = 6,  VFP = 2, VS = 2, VBP = 3;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int HAS = HS + HBP, HAE = HAS + HA, HH = HAS + HA / 2;
    localparam int VAS = VS + VBP, VAE = VAS + VA;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        hsync, vsync, pix_req, video_en, frame_start, busy;
    logic [10:0] video_hcnt, video_vcnt;
    logic [11:0] index;
    logic        hsync_n, vsync_n, pix_req_n, video_en_n, frame_start_n, busy_n;
    logic [10:0] video_hcnt_n, video_vcnt_n;
    logic [11:0] index_n;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tmds_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b1)
    ) u_dut (
        .tx0_pclk(clk), .rstbtn_n(rst), .en(en),
        .hsync(hsync), .vsync(vsync), .pix_req(pix_req), .video_en(video_en),
        .video_hcnt(video_hcnt), .video_vcnt(video_vcnt), .index(index),
        .frame_start(frame_start), .busy(busy)
    );

    tmds_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0)
    ) u_dut_n (
        .tx0_pclk(clk), .rstbtn_n(rst), .en(en),
        .hsync(hsync_n), .vsync(vsync_n), .pix_req(pix_req_n), .video_en(video_en_n),
        .video_hcnt(video_hcnt_n), .video_vcnt(video_vcnt_n), .index(index_n),
        .frame_start(frame_start_n), .busy(busy_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 run, 2 drain; m_p is the linear pixel number in the frame.
    int m_mode = 0, m_p = 0, m_idx = 0;
    bit e_hs, e_vs, e_pr, e_ve, e_fs, e_busy;
    int e_hc, e_vc, e_idx;

    // FIFO block index after the raster has passed position (h,v)
    function automatic int idx_after(int h, int v, int prev);
        int line;
        if (v < VAS || (v == VAS && h < HAS)) return prev;
        if (v >= VAE) return 2 * VA - 1;
        line = v - VAS;
        if (h < HAS) return 2 * line - 1;
        if (h < HH)  return 2 * line;
        return 2 * line + 1;
    endfunction

    task automatic model_eval();
        int h, v;
        bit v_in;
        {e_hs, e_vs, e_pr, e_ve, e_fs, e_busy} = '0;
        e_hc = 0;
        e_vc = 0;
        if (rst) begin
            m_mode = 0;
            m_p    = 0;
            m_idx  = 0;
        end else begin
            h = m_p % HT;
            v = m_p / HT;
            if (m_mode != 0) begin
                v_in   = (v >= VAS) && (v < VAE);
                e_hs   = h < HS;
                e_vs   = v < VS;
                e_ve   = v_in && (h >= HAS) && (h < HAE);
                e_pr   = v_in && (h + 1 >= HAS) && (h + 1 < HAE);
                e_hc   = e_ve ? h - HAS : 0;
                e_vc   = v_in ? v - VAS : 0;
                e_fs   = (m_p == 0);
                e_busy = 1'b1;
                m_idx  = idx_after(h, v, m_idx);
            end
            case (m_mode)
                0: if (en) m_mode = 1;
                1: begin
                    if (!en) m_mode = 2;
                    m_p = (m_p + 1) % FRAME;
                end
                default: begin
                    if (en) m_mode = 1;
                    else if (m_p == FRAME - 1) m_mode = 0;
                    m_p = (m_p + 1) % FRAME;
                end
            endcase
        end
        e_idx = m_idx;
    endtask

    // One clock: predict, let the edge happen, sample 1 time unit later and compare
    task automatic tick();
        model_eval();
        @(posedge clk);
        #1;
        check("flags", 32'({hsync, vsync, pix_req, video_en, frame_start, busy}),
              32'({e_hs, e_vs, e_pr, e_ve, e_fs, e_busy}));
        check("video_hcnt", 32'(video_hcnt), 32'(e_hc));
        check("video_vcnt", 32'(video_vcnt), 32'(e_vc));
        check("index", 32'(index), 32'(e_idx));
        check("pol0_syncs", 32'({hsync_n, vsync_n}), 32'({!e_hs, !e_vs}));
    endtask

    initial begin
        int n, fs_cnt, fs_period, ven_cnt, pr_cnt, hs_cnt, vs_cnt, idx_max;

        // Reset and idle
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Start: frame_start expected two cycles after en rises
        en = 1'b1;
        n  = 0;
        do begin
            tick();
            n++;
        end while (!frame_start && n < 10);
        check("first_fs_latency", 32'(n), 32'd2);

        // Two full frames starting at the cycle that shows (0,0)
        fs_cnt = 1; fs_period = 0;
        ven_cnt = int'(video_en); pr_cnt = int'(pix_req);
        hs_cnt = int'(hsync); vs_cnt = int'(vsync); idx_max = int'(index);
        for (int i = 1; i < 2 * FRAME; i++) begin
            tick();
            ven_cnt += int'(video_en);
            pr_cnt  += int'(pix_req);
            hs_cnt  += int'(hsync);
            vs_cnt  += int'(vsync);
            if (int'(index) > idx_max) idx_max = int'(index);
            if (frame_start) begin
                fs_cnt++;
                fs_period = i;
            end
        end
        check("fs_count", 32'(fs_cnt), 32'd2);
        check("fs_period", 32'(fs_period), 32'(FRAME));
        check("video_en_count", 32'(ven_cnt), 32'(2 * HA * VA));
        check("pix_req_count", 32'(pr_cnt), 32'(2 * HA * VA));
        check("hsync_count", 32'(hs_cnt), 32'(2 * VT * HS));
        check("vsync_count", 32'(vs_cnt), 32'(2 * VS * HT));
        check("index_max", 32'(idx_max), 32'(2 * VA - 1));

        // Brief en drop inside the frame, then resume
        repeat (120) tick();
        en = 1'b0;
        repeat (80) tick();
        en = 1'b1;
        repeat (200) tick();

        // Drop en and leave it low: the frame drains to completion
        en = 1'b0;
        n  = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 2 * FRAME + 5);
        check("drain_to_idle", 32'(busy), 32'd0);
        check("idle_syncs", 32'({hsync, vsync, hsync_n, vsync_n}), 32'b0011);
        repeat (5) tick();

        // Mid-frame reset with en held high, then a clean restart
        en = 1'b1;
        repeat (150) tick();
        rst = 1'b1;
        tick();
        check("index_after_rst", 32'(index), 32'd0);
        rst = 1'b0;
        repeat (FRAME + 20) tick();

        // Random en toggles and occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) en = ~en;
            rst = ($urandom_range(1499) == 0);
            tick();
        end
        rst = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
